inst_mem_loader: RTL and testbench
==================================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning log2 of the number of 32-bit instruction words (1024 words).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; asynchronous and active-high.
REQ-004 SHALL have port rom_ce_i, input, 1, the CPU fetch enable.
REQ-005 SHALL have port rom_addr_i, input, 32, the CPU fetch byte address.
REQ-006 SHALL have port rom_data_o, output, 32, the instruction word returned to the CPU.
REQ-007 SHALL have port load_start_i, input, 1, a one-cycle pulse that begins a program load.
REQ-008 SHALL have port load_len_i, input, ADDR_WIDTH+1, the number of words to load; sampled on load_start_i.
REQ-009 SHALL have port ld_valid_i, input, 1, indicating a load byte is offered.
REQ-010 SHALL have port ld_data_i, input, 8, the load byte.
REQ-011 SHALL have port ld_ready_o, output, 1, indicating the block can accept a load byte.
REQ-012 SHALL have port cpu_hold_o, output, 1, which holds the CPU in reset while a load is in progress.
REQ-013 SHALL have port load_done_o, output, 1, a one-cycle pulse marking load completion.

Function
REQ-014 SHALL serve CPU fetches combinationally: rom_data_o = mem[rom_addr_i[ADDR_WIDTH+1:2]] when rom_ce_i=1 and the state is not LOAD, because the CPU expects data in the same cycle as the address.
REQ-015 SHALL drive rom_data_o to 0 when rom_ce_i=0.
REQ-016 SHALL drive rom_data_o to 32'h00000013 (NOP) when rom_ce_i=1 and the state is LOAD.
REQ-017 SHALL ignore address bits above ADDR_WIDTH+1 and bits [1:0], so fetch addresses wrap modulo the memory size.
REQ-018 SHALL implement states IDLE, LOAD and DONE.
REQ-019 IDLE -> LOAD on load_start_i=1 when the clamped length is nonzero; IDLE -> DONE when it is zero.
REQ-020 SHALL clamp load_len_i to 2^ADDR_WIDTH.
REQ-021 SHALL clear the byte counter and word pointer to 0 on entry to LOAD.
REQ-022 SHALL assert ld_ready_o only in LOAD; a byte transfers in a cycle where ld_valid_i and ld_ready_o are both 1.
REQ-023 SHALL assemble bytes little-endian: byte k of each group of 4 goes to bits [8k+7:8k].
REQ-024 SHALL write mem[word_ptr] on the cycle the 4th byte is accepted, using the three stored bytes plus the current ld_data_i, then increment word_ptr; the written word SHALL be readable the following cycle.
REQ-025 SHALL go LOAD -> DONE on the cycle the last word is written; ld_ready_o SHALL deassert from the next cycle.
REQ-026 SHALL remain in DONE for exactly one cycle with load_done_o=1, then return to IDLE.
REQ-027 SHALL assert cpu_hold_o in LOAD and DONE.
REQ-028 SHALL ignore load_start_i in LOAD and DONE.
REQ-029 SHALL leave ld_data_i without effect when ld_valid_i=0, with no counter change; gaps between bytes are allowed.

Reset
REQ-030 On rst=1, asynchronously: state=IDLE, byte counter=0, word_ptr=0, byte buffer=0, load_done_o=0, ld_ready_o=0, cpu_hold_o=0.
REQ-031 Memory contents SHALL NOT be reset; reset mid-load aborts the load and leaves the words already written intact.

Structure
REQ-032 SHALL place the state encoding (IDLE/LOAD/DONE), the NOP constant, and the reuse of the existing 32-bit register-width and instruction-address-width macros in the shared defines file.
REQ-033 SHALL implement the storage array as sub-module inst_mem_array (asynchronous read, synchronous write); the FSM and byte assembly stay in the top module.

Verification
REQ-034 Load len=2, bytes 13,05,10,00,93,00,20,00 -> mem[0]=32'h00100513, mem[1]=32'h00200093; load_done_o pulses once; cpu_hold_o falls the cycle after DONE.
REQ-035 Fetch rom_ce_i=1, addr=32'h4 after REQ-034 -> rom_data_o=32'h00200093 in the same cycle; with rom_ce_i=0 -> 0.
REQ-036 Fetch during LOAD -> rom_data_o=32'h00000013; a second load_start_i mid-load -> ignored, and word_ptr continues.
REQ-037 load_start_i with len=0 -> no LOAD state, load_done_o pulses in the next cycle, ld_ready_o stays 0.
REQ-038 Assert rst after 6 of 8 bytes -> IDLE immediately, cpu_hold_o=0, mem[0] retained, mem[1] unchanged.
REQ-039 ld_valid_i toggling randomly over a len=4 load -> final words identical to the gap-free load.

Source files
------------

// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Holds the FSM state encoding, NOP word and core width constants.
package inst_mem_loader_pkg;
  localparam int REG_WIDTH       = 32;
  localparam int INST_ADDR_WIDTH = 32;

  localparam logic [REG_WIDTH-1:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: asynchronous read port, synchronous write port.
// Ports: clk, we/waddr/wdata write side, raddr -> rdata read side.
module inst_mem_array #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/inst_mem_loader.sv
// Loads a program byte stream into instruction memory, holding the CPU.
// Ports: CPU fetch (rom_*), load control/stream (load_*, ld_*), status.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rom_ce_i,
  input  logic [INST_ADDR_WIDTH-1:0] rom_addr_i,
  output logic [REG_WIDTH-1:0]       rom_data_o,
  input  logic                       load_start_i,
  input  logic [ADDR_WIDTH:0]        load_len_i,
  input  logic                       ld_valid_i,
  input  logic [7:0]                 ld_data_i,
  output logic                       ld_ready_o,
  output logic                       cpu_hold_o,
  output logic                       load_done_o
);
  localparam logic [ADDR_WIDTH:0] MAX_LEN =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t              state;
  logic [1:0]          byte_cnt;
  logic [23:0]         byte_buf;
  logic [ADDR_WIDTH:0] word_ptr;
  logic [ADDR_WIDTH:0] len_q;
  logic [ADDR_WIDTH:0] len_c;
  logic [ADDR_WIDTH:0] ptr_nxt;
  logic                take;
  logic                we;
  logic [REG_WIDTH-1:0] wdata;
  logic [REG_WIDTH-1:0] rdata;

  assign len_c   = (load_len_i > MAX_LEN) ? MAX_LEN : load_len_i;
  assign ptr_nxt = word_ptr + 1'b1;
  assign take    = ld_ready_o & ld_valid_i;
  assign we      = take & (byte_cnt == 2'd3);
  assign wdata   = {ld_data_i, byte_buf};

  inst_mem_array #(
    .AW (ADDR_WIDTH),
    .DW (REG_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (word_ptr[ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .raddr (rom_addr_i[ADDR_WIDTH+1:2]),
    .rdata (rdata)
  );

  wire unused_addr = ^{rom_addr_i[INST_ADDR_WIDTH-1:ADDR_WIDTH+2],
                       rom_addr_i[1:0]};

  always_comb begin
    rom_data_o = '0;
    if (rom_ce_i) rom_data_o = (state == LOAD) ? NOP : rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      byte_buf    <= '0;
      word_ptr    <= '0;
      len_q       <= '0;
      ld_ready_o  <= 1'b0;
      cpu_hold_o  <= 1'b0;
      load_done_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_start_i) begin
            len_q      <= len_c;
            byte_cnt   <= '0;
            word_ptr   <= '0;
            cpu_hold_o <= 1'b1;
            if (len_c == '0) begin
              state       <= DONE;
              load_done_o <= 1'b1;
            end else begin
              state      <= LOAD;
              ld_ready_o <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (take) begin
            if (byte_cnt == 2'd3) begin
              byte_cnt <= '0;
              word_ptr <= ptr_nxt;
              if (ptr_nxt == len_q) begin
                state       <= DONE;
                ld_ready_o  <= 1'b0;
                load_done_o <= 1'b1;
              end
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
              byte_buf[{byte_cnt, 3'b000} +: 8] <= ld_data_i;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          load_done_o <= 1'b0;
          cpu_hold_o  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader with a queue-based reference model.
// Checks every cycle on the falling edge plus literal expectations.
module tb_inst_mem_loader;
  localparam logic [31:0] NOPW = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        load_start_i;
  logic [10:0] load_len_i;
  logic        ld_valid_i;
  logic [7:0]  ld_data_i;
  logic        ld_ready_o;
  logic        cpu_hold_o;
  logic        load_done_o;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  inst_mem_loader #(.ADDR_WIDTH(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce_i),
    .rom_addr_i   (rom_addr_i),
    .rom_data_o   (rom_data_o),
    .load_start_i (load_start_i),
    .load_len_i   (load_len_i),
    .ld_valid_i   (ld_valid_i),
    .ld_data_i    (ld_data_i),
    .ld_ready_o   (ld_ready_o),
    .cpu_hold_o   (cpu_hold_o),
    .load_done_o  (load_done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte queue, words remaining, written-word map.
  logic [31:0] m_mem [1024];
  bit          m_vld [1024];
  logic [7:0]  m_q [$];
  bit          m_load;
  bit          m_done;
  int          m_ptr;
  int          m_len;

  task automatic model_step();
    int n;
    if (rst) begin
      m_load = 0; m_done = 0; m_ptr = 0; m_q.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (m_load) begin
      if (ld_valid_i) begin
        m_q.push_back(ld_data_i);
        if (m_q.size() == 4) begin
          m_mem[m_ptr] = {m_q[3], m_q[2], m_q[1], m_q[0]};
          m_vld[m_ptr] = 1;
          m_q.delete();
          m_ptr++;
          if (m_ptr == m_len) begin
            m_load = 0; m_done = 1;
          end
        end
      end
    end else if (load_start_i) begin
      n = int'(load_len_i);
      m_len = (n > 1024) ? 1024 : n;
      m_ptr = 0;
      m_q.delete();
      if (m_len == 0) m_done = 1;
      else m_load = 1;
    end
  endtask

  initial begin
    m_load = 0; m_done = 0; m_ptr = 0; m_len = 0;
    for (int i = 0; i < 1024; i++) m_vld[i] = 0;
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp;
    int idx;
    check("ld_ready", {31'd0, ld_ready_o}, {31'd0, m_load});
    check("cpu_hold", {31'd0, cpu_hold_o}, {31'd0, m_load | m_done});
    check("load_done", {31'd0, load_done_o}, {31'd0, m_done});
    if (load_done_o === 1'b1) done_cnt++;
    idx = int'(rom_addr_i[11:2]);
    if (!rom_ce_i) check("rom_off", rom_data_o, 32'h0);
    else if (m_load) check("rom_nop", rom_data_o, NOPW);
    else if (m_vld[idx]) begin
      exp = m_mem[idx];
      check("rom_read", rom_data_o, exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [10:0] len);
    load_start_i = 1'b1;
    load_len_i   = len;
    tick();
    load_start_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      ld_valid_i = 1'b0;
      ld_data_i  = 8'($urandom);
      tick();
    end
    ld_valid_i = 1'b1;
    ld_data_i  = b;
    tick();
    ld_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++)
      send(w[8*k +: 8], int'($urandom_range(0, maxgap)));
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp,
                       input string nm);
    rom_ce_i   = 1'b1;
    rom_addr_i = a;
    #1;
    check(nm, rom_data_o, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] wl [4];

  initial begin
    wl[0] = 32'h11223344; wl[1] = 32'h55667788;
    wl[2] = 32'hdeadbeef; wl[3] = 32'hcafef00d;
    rst = 1'b1; rom_ce_i = 1'b0; rom_addr_i = '0;
    load_start_i = 1'b0; load_len_i = '0;
    ld_valid_i = 1'b0; ld_data_i = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Basic two-word load.
    done_cnt = 0;
    start(11'd2);
    send_word(32'h00100513, 0);
    send_word(32'h00200093, 0);
    @(negedge clk);
    check("t1_done", {31'd0, load_done_o}, 32'd1);
    tick();
    @(negedge clk);
    check("t1_hold_fall", {31'd0, cpu_hold_o}, 32'd0);
    check("t1_done_once", done_cnt, 32'd1);
    check("model_w0", m_mem[0], 32'h00100513);
    tick();

    // Fetch, wrap and disabled fetch.
    fetch(32'h4, 32'h00200093, "f_w1");
    fetch(32'h0, 32'h00100513, "f_w0");
    fetch(32'hFFFF_F006, 32'h00200093, "f_wrap");
    rom_ce_i = 1'b0;
    #1;
    check("f_off", rom_data_o, 32'h0);
    tick();

    // Fetch during load and ignored restart.
    rom_ce_i = 1'b1; rom_addr_i = 32'h0;
    start(11'd4);
    send_word(wl[0], 0);
    load_start_i = 1'b1; load_len_i = 11'd1;
    tick();
    load_start_i = 1'b0;
    @(negedge clk);
    check("nop_in_load", rom_data_o, NOPW);
    for (int i = 1; i < 4; i++) send_word(wl[i], 0);
    tick();
    for (int i = 0; i < 4; i++)
      fetch(32'(i * 4), wl[i], "t3_word");
    tick();

    // Zero-length load.
    start(11'd0);
    @(negedge clk);
    check("z_done", {31'd0, load_done_o}, 32'd1);
    check("z_ready", {31'd0, ld_ready_o}, 32'd0);
    tick();
    @(negedge clk);
    check("z_done_end", {31'd0, load_done_o}, 32'd0);
    tick();

    // Reset after 6 of 8 bytes.
    start(11'd2);
    send_word(32'h0badf00d, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    rst = 1'b1;
    #1;
    check("r_hold", {31'd0, cpu_hold_o}, 32'd0);
    check("r_ready", {31'd0, ld_ready_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    fetch(32'h0, 32'h0badf00d, "r_w0");
    fetch(32'h4, 32'h55667788, "r_w1");
    tick();

    // Oversized length clamps to the full array.
    rom_ce_i = 1'b0;
    start(11'h7FF);
    for (int i = 0; i < 1024; i++)
      send_word(32'hA5000000 | 32'(i), 0);
    @(negedge clk);
    check("c_done", {31'd0, load_done_o}, 32'd1);
    tick();
    fetch(32'hFFC, 32'hA50003FF, "c_last");
    fetch(32'h10, 32'hA5000004, "c_w4");
    tick();

    // Gapped load matches the gap-free words.
    rom_ce_i = 1'b0;
    start(11'd4);
    for (int i = 0; i < 4; i++) send_word(wl[i], 3);
    tick();
    tick();
    for (int i = 0; i < 4; i++)
      fetch(32'(i * 4), wl[i], "g_word");
    tick();
    fetch(32'h10, 32'hA5000004, "g_w4");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
